checker_sequencer: RTL

CHECKER_SEQUENCER -- requirements
Module: checker_sequencer

---
 rtl/checker_sequencer_if.sv | 45 ++++
 rtl/checker_sequencer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/checker_sequencer_if.sv
// Handshake bundle between two character requesters, the sequencer and the shared block checker.
// No latency of its own; plain wires grouped for port connection.
// Backpressure: requester readies come from the sequencer, which never stalls a granted stream.
interface checker_sequencer_if;
  // requester 0
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  // requester 1
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  // shared checker
  logic [7:0] chk_in;
  logic       chk_reset;
  logic       chk_result;
  // completion / status
  logic       done;
  logic       done_id;
  logic       done_ok;
  logic       err;
  logic       busy;

  // sequencer side
  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  chk_result,
    output req0_ready, req1_ready,
    output chk_in, chk_reset,
    output done, done_id, done_ok, err, busy
  );

  // requester / checker side
  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output chk_result,
    input  req0_ready, req1_ready,
    input  chk_in, chk_reset,
    input  done, done_id, done_ok, err, busy
  );
endinterface

// File: rtl/checker_sequencer.sv
// Arbitrates two requesters onto one shared block checker and reports a per-message verdict.
// Latency: done pulses 3 cycles after the last character is accepted (FLUSH, SAMPLE, DONE).
// Backpressure: only the granted requester sees ready, and only in STREAM; a valid gap there is an error.
// Optional feature: define SEQ_ROUND_ROBIN_EN for round-robin grant; default is fixed priority to req0.
module checker_sequencer #(
  parameter int MAX_LEN = 255
) (
  input  logic               clk,
  input  logic               reset,
  checker_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    SAMPLE,
    DONE
  } state_t;

  // counter value seen while the MAX_LEN-th character is on the bus
  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);
  localparam logic [7:0] SPACE    = 8'h20;

  state_t     state;
  logic [7:0] cnt;
  logic       grant;
  logic       prio;
  logic       pick;

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;

  logic       done_q;
  logic       done_id_q;
  logic       done_ok_q;
  logic       err_q;
  logic       busy_q;

  // steer the granted requester onto common signals
  always_comb begin
    g_valid = bus.req0_valid;
    g_last  = bus.req0_last;
    g_data  = bus.req0_data;
    if (grant) begin
      g_valid = bus.req1_valid;
      g_last  = bus.req1_last;
      g_data  = bus.req1_data;
    end
  end

  // contention resolved by the pointer; otherwise whoever is asking wins
  assign pick = (bus.req0_valid && bus.req1_valid) ? prio : bus.req1_valid;

`ifdef SEQ_ROUND_ROBIN_EN
  // after each completion hand preference to the requester not just served
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (state == DONE) begin
      prio <= ~grant;
    end
  end
`else
  // fixed priority: req0 always preferred
  assign prio = 1'b0;
`endif

  // message sequencer: one FSM, all status outputs registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      grant     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      done_ok_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req0_valid || bus.req1_valid) begin
            grant  <= pick;
            busy_q <= 1'b1;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          state <= STREAM;
        end
        STREAM: begin
          if (!g_valid) begin
            // checker cannot stall, so a gap corrupts the message
            err_q     <= 1'b1;
            done_id_q <= grant;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
            if (g_last) begin
              state <= FLUSH;
            end else if (cnt == LAST_IDX) begin
              // length budget used up without a terminator
              err_q     <= 1'b1;
              done_id_q <= grant;
              done_q    <= 1'b1;
              state     <= DONE;
            end
          end
        end
        FLUSH: begin
          state <= SAMPLE;
        end
        SAMPLE: begin
          done_ok_q <= bus.chk_result;
          done_id_q <= grant;
          done_q    <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done_id_q <= 1'b0;
          done_ok_q <= 1'b0;
          err_q     <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = (state == STREAM) && !grant;
  assign bus.req1_ready = (state == STREAM) && grant;
  // trailing space in FLUSH terminates the final word inside the checker
  assign bus.chk_in     = (state == STREAM) ? g_data : SPACE;
  assign bus.chk_reset  = reset || (state == CLEAR);

  assign bus.done       = done_q;
  assign bus.done_id    = done_id_q;
  assign bus.done_ok    = done_ok_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;

endmodule
